// File: rtl/fft_result_packer_if.sv
// Handshake and frame-bus bundle between an FFT core, the result packer
// and the downstream SPI output stage.
interface fft_result_packer_if #(
  parameter int N    = 16,
  parameter int MSB  = 8,
  parameter int IN_W = 16
);
  logic                  in_valid;
  logic                  in_first;
  logic [IN_W-1:0]       in_re;
  logic [IN_W-1:0]       in_im;
  logic                  in_ready;
  logic [N*2*MSB-1:0]    data_bus;
  logic                  start_spi;
  logic                  busy;
  logic                  frame_err;

  // Sample source side: drives samples, observes the packed frame.
  modport master (
    output in_valid, in_first, in_re, in_im,
    input  in_ready, data_bus, start_spi, busy, frame_err
  );

  // Packer side.
  modport slave (
    input  in_valid, in_first, in_re, in_im,
    output in_ready, data_bus, start_spi, busy, frame_err
  );
endinterface

// File: rtl/fft_result_packer.sv
// Collects one frame of complex FFT bins (optionally in bit-reversed
// arrival order), truncates each part to its top MSB bits and presents the
// whole frame on a wide bus. A one-cycle start_spi strobe announces a
// complete frame; the bus is then frozen for HOLD_CYCLES while the SPI
// stage drains it.
module fft_result_packer #(
  parameter int N           = 16,
  parameter int MSB         = 8,
  parameter int IN_W        = 16,
  parameter int BITREV      = 1,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  fft_result_packer_if.slave bus
);

  localparam int CW = $clog2(N);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_FIRE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic          frame_err_reg, frame_err_next;

  logic [CW-1:0] cnt_rev;
  logic [CW-1:0] wr_bin;
  logic          accept;
  logic          premature;
  logic [MSB-1:0] re_byte, im_byte;

  // One byte per slot: even slots real, odd slots imaginary.
  logic [MSB-1:0] slot_reg [2*N];

  // Accepting only in FILL; reset masks ready so nothing slips in while
  // the state is being forced back.
  assign bus.in_ready = (state_reg == ST_FILL) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // A frame marker in the middle of a frame restarts the frame at bin 0.
  assign premature    = accept && bus.in_first && (cnt_reg != '0);

  generate
    for (genvar gi = 0; gi < CW; gi++) begin : g_rev
      assign cnt_rev[gi] = cnt_reg[CW-1-gi];
    end
  endgenerate

  assign wr_bin  = premature ? '0 : ((BITREV != 0) ? cnt_rev : cnt_reg);

  // Plain truncation to the top bits keeps the sign with no rounding.
  assign re_byte = bus.in_re[IN_W-1 -: MSB];
  assign im_byte = bus.in_im[IN_W-1 -: MSB];

  // Next-state logic for the FILL / FIRE / HOLD sequencing.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    hold_next      = hold_reg;
    frame_err_next = 1'b0;
    case (state_reg)
      ST_FILL: begin
        if (accept) begin
          if (premature) begin
            cnt_next       = CW'(1);
            frame_err_next = 1'b1;
          end else if (cnt_reg == CW'(N-1)) begin
            cnt_next   = '0;
            state_next = ST_FIRE;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      ST_FIRE: begin
        hold_next  = '0;
        state_next = (HOLD_CYCLES == 0) ? ST_FILL : ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_reg == HW'(HOLD_CYCLES-1)) begin
          state_next = ST_FILL;
        end else begin
          hold_next = hold_reg + HW'(1);
        end
      end
      default: state_next = ST_FILL;
    endcase
  end

  // Control state registers; reset overrides any concurrent event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_FILL;
      cnt_reg       <= '0;
      hold_reg      <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      hold_reg      <= hold_next;
      frame_err_reg <= frame_err_next;
    end
  end

  // Slot storage: only the accepted bin is written, so slots not touched
  // in a frame keep the value from an earlier frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2*N; s++) begin
        slot_reg[s] <= '0;
      end
    end else if (accept) begin
      slot_reg[{wr_bin, 1'b0}] <= re_byte;
      slot_reg[{wr_bin, 1'b1}] <= im_byte;
    end
  end

  generate
    for (genvar gi = 0; gi < 2*N; gi++) begin : g_bus
      assign bus.data_bus[gi*MSB +: MSB] = slot_reg[gi];
    end
  endgenerate

  assign bus.start_spi = (state_reg == ST_FIRE);
  assign bus.busy      = (state_reg == ST_FIRE) || (state_reg == ST_HOLD);
  assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_fft_result_packer.sv
// Bench for fft_result_packer: two instances (natural and bit-reversed
// order) share one stimulus stream and are compared every cycle against a
// frame-level model that tracks bins, accept count and ready/strobe timing.
module tb_fft_result_packer;

  localparam int N    = 4;
  localparam int MSB  = 8;
  localparam int IN_W = 16;
  localparam int H    = 10;
  localparam int LOGN = 2;

  logic clk;
  logic rst;

  fft_result_packer_if #(.N(N), .MSB(MSB), .IN_W(IN_W)) if0 ();
  fft_result_packer_if #(.N(N), .MSB(MSB), .IN_W(IN_W)) if1 ();

  fft_result_packer #(.N(N), .MSB(MSB), .IN_W(IN_W), .BITREV(0), .HOLD_CYCLES(H))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  fft_result_packer #(.N(N), .MSB(MSB), .IN_W(IN_W), .BITREV(1), .HOLD_CYCLES(H))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bytes per slot for each instance, bins accepted in the current
  // frame, and the cycles at which strobes / ready are expected.
  logic [7:0] m_slot [2][2*N];
  int cyc      = 0;
  int m_cnt    = 0;
  int m_ready_at = 0;
  int m_fire   = -1;
  int m_err    = -1;
  int n_acc    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int bin_of(input int d, input int c);
    int r;
    if (d == 0) return c;
    r = 0;
    for (int i = 0; i < LOGN; i++)
      if (((c >> i) & 1) != 0) r = r + (1 << (LOGN-1-i));
    return r;
  endfunction

  function automatic logic [63:0] packed_frame(input int d);
    logic [63:0] p;
    for (int s = 0; s < 2*N; s++) p[s*8 +: 8] = m_slot[d][s];
    return p;
  endfunction

  // One clock: drive inputs, update the model at the edge, then compare
  // every output of both instances at the following falling edge.
  task automatic step(input bit v, input bit f, input bit r,
                      input logic [15:0] re, input logic [15:0] im);
    bit acc;
    bit exp_ready;
    int b;
    rst = r;
    if0.in_valid = v; if0.in_first = f; if0.in_re = re; if0.in_im = im;
    if1.in_valid = v; if1.in_first = f; if1.in_re = re; if1.in_im = im;
    acc = v && !r && (cyc >= m_ready_at);
    @(posedge clk);
    cyc++;
    if (r) begin
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < 2*N; s++) m_slot[d][s] = 8'h00;
      m_cnt = 0; m_ready_at = cyc; m_fire = -1; m_err = -1;
    end else if (acc) begin
      n_acc++;
      $display("txn cyc=%0d bin_cnt=%0d first=%0d re=%h im=%h", cyc, m_cnt, f, re, im);
      if (f && m_cnt != 0) begin
        for (int d = 0; d < 2; d++) begin
          m_slot[d][0] = re[15:8];
          m_slot[d][1] = im[15:8];
        end
        m_cnt = 1;
        m_err = cyc;
      end else begin
        for (int d = 0; d < 2; d++) begin
          b = bin_of(d, m_cnt);
          m_slot[d][2*b]   = re[15:8];
          m_slot[d][2*b+1] = im[15:8];
        end
        if (m_cnt == N-1) begin
          m_cnt = 0;
          m_fire = cyc;
          m_ready_at = cyc + 1 + H;
        end else begin
          m_cnt++;
        end
      end
    end
    @(negedge clk);
    exp_ready = !r && (cyc >= m_ready_at);
    check("ready0", 64'(if0.in_ready), 64'(exp_ready));
    check("ready1", 64'(if1.in_ready), 64'(exp_ready));
    check("start0", 64'(if0.start_spi), 64'(cyc == m_fire));
    check("start1", 64'(if1.start_spi), 64'(cyc == m_fire));
    check("busy0", 64'(if0.busy), 64'(cyc < m_ready_at));
    check("busy1", 64'(if1.busy), 64'(cyc < m_ready_at));
    check("ferr0", 64'(if0.frame_err), 64'(cyc == m_err));
    check("ferr1", 64'(if1.frame_err), 64'(cyc == m_err));
    check("bus0", if0.data_bus, packed_frame(0));
    check("bus1", if1.data_bus, packed_frame(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    logic [15:0] re_tab [4];
    logic [15:0] rr, ri;
    int low_cnt, fire_cnt, acc_base;
    bit fv, ff, fr;

    rst = 1'b1;
    if0.in_valid = 1'b0; if0.in_first = 1'b0; if0.in_re = '0; if0.in_im = '0;
    if1.in_valid = 1'b0; if1.in_first = 1'b0; if1.in_re = '0; if1.in_im = '0;

    // Reset state, with a valid sample offered during reset.
    step(1'b1, 1'b1, 1'b1, 16'h1234, 16'h5678);
    check("rst_bus", if0.data_bus, 64'h0);
    check("rst_busy", 64'(if0.busy), 64'h0);
    idle(1);
    check("post_rst_ready", 64'(if0.in_ready), 64'h1);

    // Natural-order frame with ascending reals and 0xFF imaginaries.
    for (int k = 0; k < 4; k++)
      step(1'b1, k == 0, 1'b0, 16'(16'h0100 * (k+1)), 16'hFF00);
    check("nat_frame", if0.data_bus, 64'hFF04FF03FF02FF01);
    check("nat_frame_rev", if1.data_bus, 64'hFF04FF02FF03FF01);
    check("nat_start", 64'(if0.start_spi), 64'h1);
    idle(12);

    // Bit-reversed arrival order.
    re_tab[0] = 16'h0A00; re_tab[1] = 16'h0B00; re_tab[2] = 16'h0C00; re_tab[3] = 16'h0D00;
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, 1'b0, re_tab[k], 16'h0000);
    check("rev_frame", if1.data_bus, 64'h000D000B000C000A);
    idle(12);

    // Truncation keeps the sign and never saturates.
    re_tab[0] = 16'h8001; re_tab[1] = 16'h7FFF; re_tab[2] = 16'h0000; re_tab[3] = 16'h0000;
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, 1'b0, re_tab[k], 16'h0000);
    check("trunc_frame", if0.data_bus, 64'h00000000007F0080);
    idle(12);

    // in_valid held high across two frames.
    low_cnt = 0; fire_cnt = 0; acc_base = n_acc;
    for (int i = 0; i < 19; i++) begin
      step(1'b1, ((n_acc - acc_base) % 4) == 0, 1'b0,
           16'(16'h1100 * (n_acc - acc_base + 1)), 16'(16'h0300 * (n_acc - acc_base)));
      if (i < 18 && !if0.in_ready) low_cnt++;
      if (if0.start_spi) fire_cnt++;
    end
    check("b2b_ready_low", 64'(low_cnt), 64'd11);
    check("b2b_accepts", 64'(n_acc - acc_base), 64'd8);
    check("b2b_fires", 64'(fire_cnt), 64'd2);
    idle(12);

    // Premature frame marker after two accepts.
    step(1'b1, 1'b1, 1'b0, 16'h2100, 16'h2200);
    step(1'b1, 1'b0, 1'b0, 16'h2300, 16'h2400);
    step(1'b1, 1'b1, 1'b0, 16'h2500, 16'h2600);
    check("premature_err", 64'(if0.frame_err), 64'h1);
    step(1'b1, 1'b0, 1'b0, 16'h2700, 16'h2800);
    check("premature_err_once", 64'(if0.frame_err), 64'h0);
    step(1'b1, 1'b0, 1'b0, 16'h2900, 16'h2A00);
    check("premature_no_start", 64'(if0.start_spi), 64'h0);
    step(1'b1, 1'b0, 1'b0, 16'h2B00, 16'h2C00);
    check("premature_start", 64'(if0.start_spi), 64'h1);
    idle(12);

    // Reset in the middle of HOLD.
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, 1'b0, 16'h4400, 16'h5500);
    idle(5);
    step(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
    check("hold_rst_bus", if0.data_bus, 64'h0);
    check("hold_rst_busy", 64'(if0.busy), 64'h0);
    idle(1);
    check("hold_rst_ready", 64'(if0.in_ready), 64'h1);
    for (int k = 0; k < 4; k++) step(1'b1, k == 0, 1'b0, 16'h6600, 16'h7700);
    check("hold_rst_refire", 64'(if0.start_spi), 64'h1);

    // Randomized traffic with occasional stray markers and resets.
    for (int i = 0; i < 400; i++) begin
      fv = ($urandom_range(0, 9) < 7);
      ff = (m_cnt == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      fr = ($urandom_range(0, 149) == 0);
      rr = 16'($urandom);
      ri = 16'($urandom);
      step(fv, ff, fr, rr, ri);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_result_packer.md
FFT_RESULT_PACKER -- requirements
Module: fft_result_packer

Interface
REQ-001 SHALL have parameter N, default 16, the number of complex FFT bins per frame; power of two, N >= 2.
REQ-002 SHALL have parameter MSB, default 8, the output byte width per real or imaginary slot.
REQ-003 SHALL have parameter IN_W, default 16, the input sample width; IN_W >= MSB.
REQ-004 SHALL have parameter BITREV, default 1: 1 = input arrives in bit-reversed bin order, 0 = natural order.
REQ-005 SHALL have parameter HOLD_CYCLES, default 1024, the number of cycles data_bus is frozen after start_spi so the SPI stage can drain it.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: an FFT output sample is present.
REQ-009 SHALL have port in_first, input, 1 bit: qualifies the sample as bin 0 of a frame.
REQ-010 SHALL have ports in_re and in_im, inputs, IN_W bits each: signed real and imaginary parts.
REQ-011 SHALL have port in_ready, output, 1 bit: the sample is accepted on a posedge where in_valid and in_ready are both 1.
REQ-012 SHALL have port data_bus, output, N*2*MSB bits: the packed frame, slot s at bits [(s+1)*MSB-1 : s*MSB].
REQ-013 SHALL have port start_spi, output, 1 bit: a one-cycle frame-ready strobe for the downstream SPI output stage.
REQ-014 SHALL have port busy, output, 1 bit: high in FIRE and HOLD.
REQ-015 SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a premature in_first.

Function
REQ-016 SHALL implement the states FILL, FIRE and HOLD; in_ready = (state == FILL) and not rst, derived combinationally from state.
REQ-017 In FILL, each accepted sample SHALL write bin index b = BITREV ? bit-reverse(cnt) over log2(N) bits : cnt, where cnt is the accept counter.
REQ-018 Bin b SHALL write the real part to slot 2b and the imaginary part to slot 2b+1; the write becomes visible on data_bus the cycle after acceptance.
REQ-019 Each slot value SHALL be input[IN_W-1 -: MSB], the top MSB bits with sign preserved, with no rounding and no saturation.
REQ-020 An accept with cnt = N-1 SHALL move FILL to FIRE and reset cnt to 0; otherwise an accept SHALL increment cnt.
REQ-021 FIRE SHALL last exactly 1 cycle, with start_spi = 1 and data_bus holding all N bins; it then moves to HOLD.
REQ-022 HOLD SHALL last exactly HOLD_CYCLES cycles, with in_ready = 0 and data_bus unchanged; it then returns to FILL.
REQ-023 Latency: the last accept at edge t SHALL give start_spi high during cycle t+1 and in_ready high again at cycle t+2+HOLD_CYCLES.
REQ-024 An accepted in_first with cnt = 0 SHALL be normal, and a sample at cnt = 0 without in_first SHALL also be accepted normally.
REQ-025 An accepted in_first with cnt != 0 SHALL write bin 0, set cnt to 1 and pulse frame_err for 1 cycle; the partial frame is discarded and start_spi is not asserted.
REQ-026 The input SHALL be ignored while in_ready = 0; in_first outside FILL SHALL have no effect.
REQ-027 data_bus SHALL NOT be cleared between frames; unwritten slots keep their previous frame's values.
REQ-028 start_spi SHALL never be high for 2 consecutive cycles.

Reset
REQ-029 With rst = 1 at a posedge, the next cycle SHALL have state = FILL, cnt = 0, data_bus = 0, start_spi = 0, frame_err = 0 and busy = 0.
REQ-030 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst is low.
REQ-031 Reset SHALL take priority over all events, including mid-FILL, FIRE and HOLD, and an accept in the same cycle.

Verification (N=4, MSB=8, IN_W=16, HOLD_CYCLES=10)
REQ-032 BITREV=0, in_re = 0x0100*(k+1), in_im = 0xFF00 for k = 0..3 -> one start_spi pulse the cycle after the 4th accept; data_bus = 0xFF04FF03FF02FF01.
REQ-033 BITREV=1, in_re = 0x0A00, 0x0B00, 0x0C00, 0x0D00, in_im = 0 -> real slots 0, 2, 4, 6 = 0x0A, 0x0C, 0x0B, 0x0D.
REQ-034 in_valid held high across 2 frames -> in_ready low for exactly 11 cycles after frame 1; 8 accepts total; no sample lost or duplicated; 2 start_spi pulses.
REQ-035 2 accepts, then in_first -> frame_err pulses 1 cycle; start_spi follows only after 3 further accepts.
REQ-036 rst pulsed for 1 cycle mid-HOLD -> data_bus = 0, busy = 0, in_ready = 1 the following cycle, and the next frame fires after 4 accepts.
REQ-037 in_re = 0x8001 -> slot 0x80; in_re = 0x7FFF -> slot 0x7F.
